// File: rtl/bram_pkg.sv
// Purpose : shared types and constants for the BRAM port master and its response FIFO.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package bram_pkg;

    // Controller sequencing: BOOT for one cycle, optional INIT clear, then RUN forever.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Response buffering depth; the read credit is derived from this.
    localparam int RSP_FIFO_DEPTH  = 2;

    // BRAM dout appears this many cycles after an en=1, we=0 cycle.
    localparam int BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Purpose : 2-entry response FIFO holding BRAM read data until the consumer takes it.
// Latency : push at cycle N is visible on pop_dat_o / count_o at N+1 (registered storage).
// Backpressure: no ready outputs; the producer must never push into a full FIFO (asserted).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push_i          write push_dat_i into the tail
//   push_dat_i      data to store
//   pop_i           discard the head entry
//   pop_dat_o       head entry (meaningful only while count_o != 0)
//   count_o         number of stored entries, 0..2
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_dat_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign pop_dat_o = slot_q[rd_ptr_q];
    assign count_o   = count_q;

    // The credit scheme upstream guarantees neither of these can happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (count_q == 2'(RSP_FIFO_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (count_q == 2'd0)));

endmodule

// File: rtl/bram_port_master.sv
// Purpose : turns a valid/ready request stream into BRAM port cycles and returns read data in order.
// Latency : read accepted at cycle N -> rsp_valid at N+2; writes produce no response.
// Backpressure: reads stall (req_ready=0) when the 2-entry response path is full; writes always accepted in RUN.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake; req_we, req_addr, req_wdata qualify it
//   rsp_valid/rsp_ready, rsp_rdata   read response handshake and data
//   init_done                        high once the optional post-reset clear has finished
//   mem_en/mem_we/mem_addr/mem_din   BRAM port controls (addr/din forced to 0 while en=0)
//   mem_dout                         BRAM registered read data (1-cycle latency, read-first)
module bram_port_master
    import bram_pkg::*;
#(
    parameter int                        DATA_WIDTH = 8,
    parameter int                        ADDR_WIDTH = 4,
    parameter int                        INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  inflight_q, inflight_d;

    logic                  run;
    logic                  req_fire;
    logic                  rsp_pop;
    logic [1:0]            fifo_count;
    logic [2:0]            credit;

    assign run = (state_q == ST_RUN);

    // Response side: FIFO occupancy drives rsp_valid directly.
    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_pop   = rsp_valid & rsp_ready;

    // Free response slots: every stored entry and every read still inside the BRAM
    // holds one; an entry leaving this cycle frees one early so throughput stays 1/cycle.
    // Never negative because count + inflight cannot exceed the FIFO depth.
    assign credit = 3'(RSP_FIFO_DEPTH)
                  - {1'b0, fifo_count}
                  - {2'b0, inflight_q}
                  + {2'b0, rsp_pop};

    assign req_ready  = run & (req_we | (credit != 3'd0));
    assign req_fire   = req_valid & req_ready;
    assign inflight_d = req_fire & ~req_we;
    assign init_done  = run;

    // Next-state and BRAM port mux.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;

        case (state_q)
            ST_BOOT: begin
                state_d = (INIT_EN != 0) ? ST_INIT : ST_RUN;
            end
            ST_INIT: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = init_cnt_q;
                mem_din    = INIT_VALUE;
                // Wraps to 0 on the last address; the counter is not used again until reset.
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_fire) begin
                    mem_en   = 1'b1;
                    mem_we   = req_we;
                    mem_addr = req_addr;
                    mem_din  = req_wdata;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            init_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // mem_dout is only captured the cycle after a read; write-cycle dout is ignored.
    bram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_dat_i (mem_dout),
        .pop_i      (rsp_pop),
        .pop_dat_o  (rsp_rdata),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_bram_port_master.sv
// Purpose : directed self-checking bench for bram_port_master with a behavioural read-first BRAM.
// Latency : drives inputs 1 time unit after posedge, samples 1 time unit later.
// Backpressure: rsp_ready is driven explicitly per scenario.
module tb_bram_port_master;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       mem_en;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    // Second instance without the clear sequence.
    logic       rst2_n;
    logic       req_valid2;
    logic       req_ready2;
    logic       rsp_valid2;
    logic [7:0] rsp_rdata2;
    logic       init_done2;
    logic       mem_en2;
    logic       mem_we2;
    logic [3:0] mem_addr2;
    logic [7:0] mem_din2;
    logic [7:0] zero8;
    logic [3:0] zero4;
    logic       zero1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] bram [16];

    bram_port_master #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .INIT_EN    (1),
        .INIT_VALUE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    bram_port_master #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .INIT_EN    (0),
        .INIT_VALUE (8'h00)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .req_valid (req_valid2),
        .req_ready (req_ready2),
        .req_we    (zero1),
        .req_addr  (zero4),
        .req_wdata (zero8),
        .rsp_valid (rsp_valid2),
        .rsp_ready (zero1),
        .rsp_rdata (rsp_rdata2),
        .init_done (init_done2),
        .mem_en    (mem_en2),
        .mem_we    (mem_we2),
        .mem_addr  (mem_addr2),
        .mem_din   (mem_din2),
        .mem_dout  (zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: registered dout, read-first on writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_din;
            mem_dout <= bram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, init_done, mem_en, mem_we, mem_addr, mem_din} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {req_ready, rsp_valid, init_done, mem_en, mem_we, mem_addr, mem_din}, 17'h0);
        end
        n_checks++;
        if ({req_ready2, rsp_valid2, init_done2, mem_en2} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_noinit: got %b expected 0000",
                     {req_ready2, rsp_valid2, init_done2, mem_en2});
        end
    endtask

    // Releases reset and checks the 16-cycle clear plus init_done on cycle 17.
    task automatic run_clear(input string tag);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if ({init_done, req_ready, mem_en, mem_we, mem_addr, mem_din} !== {2'b00, 2'b11, 4'(k - 1), 8'hA5}) begin
                n_fail++;
                $display("FAIL %s_write%0d: got %h expected %h", tag, k - 1,
                         {init_done, req_ready, mem_en, mem_we, mem_addr, mem_din},
                         {2'b00, 2'b11, 4'(k - 1), 8'hA5});
            end
        end
        tick();
        n_checks++;
        if ({init_done, mem_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_done: got %b expected 10", tag, {init_done, mem_en});
        end
    endtask

    task automatic test_init_clear();
        run_clear("init");
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
        #1;
        n_checks++;
        if ({req_ready, mem_en, mem_we, mem_addr} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL rd0_issue: got %b expected 1100000", {req_ready, mem_en, mem_we, mem_addr});
        end
        tick();
        req_addr = 4'd15;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd15_issue: got %b expected 10", {req_ready, rsp_valid});
        end
        tick();
        req_valid = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL rd0_data: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL rd15_data: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL init_drain: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_after_write();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 8'h3C;
        #1;
        n_checks++;
        if ({req_ready, mem_en, mem_we, mem_addr, mem_din} !== {3'b111, 4'd7, 8'h3C}) begin
            n_fail++;
            $display("FAIL raw_write: got %h expected %h",
                     {req_ready, mem_en, mem_we, mem_addr, mem_din}, {3'b111, 4'd7, 8'h3C});
        end
        tick();
        req_we = 1'b0;
        #1;
        tick();
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_early: got %b expected 0", rsp_valid);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL raw_data: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h3C});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(i); req_wdata = 8'h10 + 8'(i);
            #1;
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_wr_ready%0d: got %b expected 1", i, req_ready);
            end
            tick();
        end
        for (int j = 0; j <= 18; j++) begin
            if (j < 16) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(j);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (j < 16) begin
                n_checks++;
                if (req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_rd_ready%0d: got %b expected 1", j, req_ready);
                end
            end
            n_checks++;
            if (j >= 2 && j < 18) begin
                if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h10 + 8'(j - 2)}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: got %h expected %h", j - 2,
                             {rsp_valid, rsp_rdata}, {1'b1, 8'h10 + 8'(j - 2)});
                end
            end else if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle%0d: got %b expected 0", j, rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first: got %b expected 1", req_ready);
        end
        tick();
        req_addr = 4'd2;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second: got %b expected 1", req_ready);
        end
        tick();
        req_addr = 4'd4;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall_a: got %b expected 0", req_ready);
        end
        tick();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {2'b01, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_stall_b: got %h expected %h", {req_ready, rsp_valid, rsp_rdata}, {2'b01, 8'h11});
        end
        req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'h77;
        #1;
        n_checks++;
        if ({req_ready, mem_en, mem_we, mem_addr} !== {3'b111, 4'd3}) begin
            n_fail++;
            $display("FAIL bp_write: got %b expected 1110011", {req_ready, mem_en, mem_we, mem_addr});
        end
        tick();
        req_we = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, mem_en} !== 2'b00) begin
            n_fail++; $display("FAIL bp_stall_c: got %b expected 00", {req_ready, mem_en});
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {2'b11, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_resume: got %h expected %h", {req_ready, rsp_valid, rsp_rdata}, {2'b11, 8'h11});
        end
        tick();
        req_valid = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL bp_drain2: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h12});
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h77}) begin
            n_fail++;
            $display("FAIL bp_rd3: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h77});
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_init();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 4'd5}) begin
            n_fail++; $display("FAIL mid_init_pos: got %h expected %h", {mem_en, mem_addr}, {1'b1, 4'd5});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, init_done, mem_en, mem_we, mem_addr, mem_din} !== 17'h0) begin
            n_fail++;
            $display("FAIL mid_init_reset: got %h expected %h",
                     {req_ready, rsp_valid, init_done, mem_en, mem_we, mem_addr, mem_din}, 17'h0);
        end
        tick();
        run_clear("reclear");
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL reclear_rd9: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 8'hA5});
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        bit seen_rsp;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        tick();
        req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL inflight_setup: got %b expected 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready, mem_en} !== 3'b000) begin
            n_fail++; $display("FAIL inflight_reset: got %b expected 000", {rsp_valid, req_ready, mem_en});
        end
        tick();
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
        end
        n_checks++;
        if ({seen_rsp, init_done} !== 2'b01) begin
            n_fail++; $display("FAIL inflight_discard: got %b expected 01", {seen_rsp, init_done});
        end

        rst2_n = 1'b1;
        #1;
        n_checks++;
        if (init_done2 !== 1'b0) begin
            n_fail++; $display("FAIL noinit_boot: got %b expected 0", init_done2);
        end
        tick();
        n_checks++;
        if ({init_done2, req_ready2, mem_en2, rsp_valid2} !== 4'b1100) begin
            n_fail++;
            $display("FAIL noinit_run: got %b expected 1100", {init_done2, req_ready2, mem_en2, rsp_valid2});
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; req_valid2 = 1'b0;
        zero8 = '0; zero4 = '0; zero1 = 1'b0;

        test_reset();
        test_init_clear();
        test_read_after_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_init();
        test_reset_inflight();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
